fp_window_ctrl: RTL and testbench

- Sequencer for the windowed 16x16 register file. The file exposes an 8-register read window starting at frame pointer FP.
- Accepts CALL/RTN requests from the control unit and keeps a hardware stack of call offsets. It checks window bounds, then drives the file's New_FP / FP_move / FP_push_up for exactly one cycle per accepted move.
- Sits between the instruction decoder and the register file. Reports completion and faults back to the decoder.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/fp_offset_stack.sv | 35 +++
 rtl/fp_window_ctrl.sv | 107 ++++++++++
 tb/tb_fp_window_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, fault codes and frame-pointer geometry for the window controller.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, DONE, FAULT} state_t;
    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_WIN_OVF = 2'b01;
    localparam logic [1:0] FC_STK_OVF = 2'b10;
    localparam logic [1:0] FC_STK_UDF = 2'b11;
    localparam int FP_W     = 4;
    localparam int WIN_SIZE = 8;
endpackage

// File: rtl/fp_offset_stack.sv
// fp_offset_stack: LIFO of 3-bit CALL offsets indexed by occupancy; full/empty are guarded by the caller.
module fp_offset_stack #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [2:0] i_data,
    output logic [2:0] o_top,
    output logic [3:0] o_depth,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [2:0] r_mem [DEPTH];
    logic [3:0] r_depth;
    logic [3:0] w_tidx;
    assign w_tidx  = r_depth - 4'd1;
    assign o_top   = r_mem[w_tidx[AW-1:0]];
    assign o_depth = r_depth;
    assign o_full  = (r_depth == 4'(DEPTH));
    assign o_empty = (r_depth == 4'd0);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_depth[AW-1:0]] <= i_data;
            r_depth <= r_depth + 4'd1;
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - 4'd1;
        end
    end
endmodule

// File: rtl/fp_window_ctrl.sv
// fp_window_ctrl: CALL/RTN sequencer for the windowed register file; bounds-checks moves and strobes New_FP for one cycle.
module fp_window_ctrl
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int FP_MAX      = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_call_req,
    input  logic            i_rtn_req,
    input  logic [2:0]      i_offset,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_fault,
    output logic [1:0]      o_fault_code,
    output logic [FP_W-1:0] o_new_fp,
    output logic            o_fp_move,
    output logic            o_fp_push_up,
    output logic [FP_W-1:0] o_cur_fp,
    output logic [3:0]      o_depth
);
    state_t          r_state;
    logic [FP_W-1:0] r_cur_fp, r_new_fp;
    logic [2:0]      r_offset;
    logic [1:0]      r_fault_code;
    logic            r_is_call, r_push_up, r_fp_move, r_done, r_fault;
    logic [2:0]      w_top;
    logic            w_full, w_empty;
    logic [FP_W:0]   w_sum;
    assign w_sum = {1'b0, r_cur_fp} + {2'b00, i_offset};
    fp_offset_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_state == MOVE && r_is_call),
        .i_pop   (r_state == MOVE && !r_is_call),
        .i_data  (r_offset),
        .o_top   (w_top),
        .o_depth (o_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cur_fp     <= '0;
            r_new_fp     <= '0;
            r_offset     <= '0;
            r_fault_code <= FC_NONE;
            r_is_call    <= 1'b0;
            r_push_up    <= 1'b0;
            r_fp_move    <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_fp_move    <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            case (r_state)
                IDLE: begin
                    // CALL wins when both requests are raised together
                    if (i_call_req) begin
                        r_is_call <= 1'b1;
                        r_offset  <= i_offset;
                        if (w_full || w_sum > (FP_W+1)'(FP_MAX)) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= w_full ? FC_STK_OVF : FC_WIN_OVF;
                            r_state      <= FAULT;
                        end else begin
                            r_new_fp  <= w_sum[FP_W-1:0];
                            r_push_up <= 1'b1;
                            r_fp_move <= 1'b1;
                            r_state   <= MOVE;
                        end
                    end else if (i_rtn_req) begin
                        r_is_call <= 1'b0;
                        if (w_empty) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FC_STK_UDF;
                            r_state      <= FAULT;
                        end else begin
                            r_new_fp  <= r_cur_fp - {1'b0, w_top};
                            r_push_up <= 1'b0;
                            r_fp_move <= 1'b1;
                            r_state   <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    r_cur_fp <= r_new_fp;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_busy       = (r_state != IDLE);
    assign o_done       = r_done;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;
    assign o_new_fp     = r_new_fp;
    assign o_fp_move    = r_fp_move;
    assign o_fp_push_up = r_push_up;
    assign o_cur_fp     = r_cur_fp;
endmodule

// File: tb/tb_fp_window_ctrl.sv
// tb_fp_window_ctrl: directed CALL/RTN sequences with hand-computed frame pointers, depths and fault codes.
module tb_fp_window_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, call_req = 1'b0, rtn_req = 1'b0;
    logic [2:0] offset = 3'd0;
    logic       busy, done, fault, fp_move, push_up;
    logic [1:0] fault_code;
    logic [3:0] new_fp, cur_fp, depth;
    int checks = 0, failures = 0;
    fp_window_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_call_req(call_req), .i_rtn_req(rtn_req),
        .i_offset(offset), .o_busy(busy), .o_done(done), .o_fault(fault),
        .o_fault_code(fault_code), .o_new_fp(new_fp), .o_fp_move(fp_move),
        .o_fp_push_up(push_up), .o_cur_fp(cur_fp), .o_depth(depth)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic idle_chk(input string tag, input logic [3:0] exp_fp, input logic [3:0] exp_depth);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_pulses"}, {5'd0, done, fault, fp_move}, 8'd0);
        chk({tag, "_code"}, {6'd0, fault_code}, 8'd0);
        chk({tag, "_cur_fp"}, {4'd0, cur_fp}, {4'd0, exp_fp});
        chk({tag, "_depth"}, {4'd0, depth}, {4'd0, exp_depth});
    endtask
    // is_call selects the request; the offset is scrambled once accepted to prove it was latched
    task automatic do_move(input string tag, input logic is_call, input logic [2:0] off,
                           input logic [3:0] exp_fp, input logic [3:0] exp_depth);
        call_req = is_call;
        rtn_req  = !is_call;
        offset   = off;
        tick();
        offset = ~off;
        chk({tag, "_move"}, {5'd0, busy, fp_move, push_up}, {5'd0, 1'b1, 1'b1, is_call});
        chk({tag, "_new_fp"}, {4'd0, new_fp}, {4'd0, exp_fp});
        tick();
        chk({tag, "_done"}, {6'd0, done, fault}, 8'd2);
        chk({tag, "_cur_fp"}, {4'd0, cur_fp}, {4'd0, exp_fp});
        chk({tag, "_depth"}, {4'd0, depth}, {4'd0, exp_depth});
        call_req = 1'b0;
        rtn_req  = 1'b0;
        tick();
        idle_chk({tag, "_idle"}, exp_fp, exp_depth);
    endtask
    task automatic do_fault(input string tag, input logic is_call, input logic [2:0] off,
                            input logic [1:0] exp_code, input logic [3:0] exp_fp, input logic [3:0] exp_depth);
        call_req = is_call;
        rtn_req  = !is_call;
        offset   = off;
        tick();
        chk({tag, "_fault"}, {5'd0, fault, fp_move, done}, 8'd4);
        chk({tag, "_code"}, {6'd0, fault_code}, {6'd0, exp_code});
        chk({tag, "_cur_fp"}, {4'd0, cur_fp}, {4'd0, exp_fp});
        chk({tag, "_depth"}, {4'd0, depth}, {4'd0, exp_depth});
        call_req = 1'b0;
        rtn_req  = 1'b0;
        tick();
        idle_chk({tag, "_idle"}, exp_fp, exp_depth);
    endtask
    initial begin
        #2;
        idle_chk("reset", 4'd0, 4'd0);
        chk("reset_new_fp", {3'd0, new_fp, push_up}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        idle_chk("no_req", 4'd0, 4'd0);
        do_move("call3", 1'b1, 3'd3, 4'd3, 4'd1);
        do_move("call5", 1'b1, 3'd5, 4'd8, 4'd2);
        do_fault("win_ovf", 1'b1, 3'd1, 2'b01, 4'd8, 4'd2);
        do_move("rtn1", 1'b0, 3'd7, 4'd3, 4'd1);
        do_move("rtn2", 1'b0, 3'd7, 4'd0, 4'd0);
        do_fault("stk_udf", 1'b0, 3'd0, 2'b11, 4'd0, 4'd0);
        for (int i = 1; i <= 8; i++) do_move("call1", 1'b1, 3'd1, 4'(i), 4'(i));
        do_fault("stk_ovf", 1'b1, 3'd0, 2'b10, 4'd8, 4'd8);
        rst_n = 1'b0;
        #1;
        idle_chk("reset2", 4'd0, 4'd0);
        tick();
        rst_n = 1'b1;
        do_move("call2", 1'b1, 3'd2, 4'd2, 4'd1);
        call_req = 1'b1;
        rtn_req  = 1'b1;
        offset   = 3'd2;
        tick();
        chk("both_move", {5'd0, fp_move, push_up, 1'b0}, 8'd6);
        chk("both_new_fp", {4'd0, new_fp}, 8'd4);
        tick();
        chk("both_done", {7'd0, done}, 8'd1);
        chk("both_depth", {4'd0, depth}, 8'd2);
        call_req = 1'b0;
        rtn_req  = 1'b0;
        tick();
        idle_chk("both_idle", 4'd4, 4'd2);
        do_move("call0", 1'b1, 3'd0, 4'd4, 4'd3);
        call_req = 1'b1;
        offset   = 3'd1;
        tick();
        chk("abort_move", {7'd0, fp_move}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        call_req = 1'b0;
        idle_chk("abort", 4'd0, 4'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk("abort_after", 4'd0, 4'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
